priority_encoder_4to2: RTL and testbench

- Registered 4-input priority encoder.
- Reports the index of the highest-numbered asserted request bit, a valid flag, and a one-hot grant vector.
- Used as a small arbitration/index-extraction stage. Outputs are registered so they can drive downstream logic without a long combinational path.

---
 rtl/prio_enc_pkg.sv | 9 +
 rtl/prio_enc_core.sv | 23 ++
 rtl/priority_encoder_4to2.sv | 47 ++++
 tb/tb_priority_encoder_4to2.sv | 103 ++++++++++
 4 files changed

// File: rtl/prio_enc_pkg.sv
// prio_enc_pkg: shared widths, idle index and one-hot helper for the priority encoder
package prio_enc_pkg;
  localparam int N_IN = 4;
  localparam int IDX_W = $clog2(N_IN);
  localparam logic [IDX_W-1:0] IDX_NONE = '0;
  function automatic logic [N_IN-1:0] onehot_from_idx(input logic [IDX_W-1:0] idx);
    return N_IN'(1) << idx;
  endfunction
endpackage

// File: rtl/prio_enc_core.sv
// prio_enc_core: combinational MSB-first priority scan producing index, any-hit and one-hot
module prio_enc_core #(
  parameter int N_IN = prio_enc_pkg::N_IN,
  parameter int IDX_W = $clog2(N_IN)
) (
  input  logic [N_IN-1:0]  d,
  output logic [IDX_W-1:0] idx,
  output logic             any,
  output logic [N_IN-1:0]  onehot
);
  import prio_enc_pkg::*;
  always_comb begin
    idx = IDX_NONE;
    any = 1'b0;
    onehot = '0;
    for (int i = N_IN - 1; i >= 0; i--)
      if (!any && d[i]) begin
        idx = IDX_W'(i);
        any = 1'b1;
        onehot[i] = 1'b1;
      end
  end
endmodule

// File: rtl/priority_encoder_4to2.sv
// priority_encoder_4to2: enable-gated, async-reset output register around prio_enc_core
module priority_encoder_4to2 #(
  parameter int N_IN = prio_enc_pkg::N_IN,
  parameter int IDX_W = $clog2(N_IN)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [N_IN-1:0]  d,
  output logic [IDX_W-1:0] y,
  output logic             valid,
  output logic [N_IN-1:0]  grant
);
  import prio_enc_pkg::*;
  logic [IDX_W-1:0] idx, y_d, y_q;
  logic             any, valid_d, valid_q;
  logic [N_IN-1:0]  onehot, grant_d, grant_q;
  prio_enc_core #(.N_IN(N_IN), .IDX_W(IDX_W)) u_core (
    .d(d),
    .idx(idx),
    .any(any),
    .onehot(onehot)
  );
  always_comb begin
    y_d = en ? idx : y_q;
    valid_d = en ? any : valid_q;
    grant_d = en ? onehot : grant_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      y_q <= IDX_NONE;
      valid_q <= 1'b0;
      grant_q <= '0;
    end else begin
      y_q <= y_d;
      valid_q <= valid_d;
      grant_q <= grant_d;
    end
  assign y = y_q;
  assign valid = valid_q;
  assign grant = grant_q;
  a_no_x: assert property (@(posedge clk) disable iff (!rst_n) en |-> !$isunknown(d));
  a_idle: assert property (@(posedge clk) !valid_q |-> (y_q == IDX_NONE && grant_q == '0));
  if (N_IN == prio_enc_pkg::N_IN) begin : g_chk
    a_onehot: assert property (@(posedge clk) valid_q |-> grant_q == onehot_from_idx(y_q));
  end
endmodule

// File: tb/tb_priority_encoder_4to2.sv
// tb_priority_encoder_4to2: directed-vector self-checking bench for priority_encoder_4to2
module tb_priority_encoder_4to2;
  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       en = 1'b1;
  logic [3:0] d = 4'b1111;
  logic [1:0] y;
  logic       valid;
  logic [3:0] grant;
  int         n_cmp = 0;
  int         n_bad = 0;
  bit         inv_on = 1'b0;
  priority_encoder_4to2 dut (
    .clk(clk),
    .rst_n(rst_n),
    .en(en),
    .d(d),
    .y(y),
    .valid(valid),
    .grant(grant)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [7:0] pk(input logic v, input logic [1:0] yy, input logic [3:0] g);
    return {1'b0, v, yy, g};
  endfunction
  function automatic logic [7:0] model(input logic [3:0] dv);
    logic [1:0] yy = 2'd0;
    logic       v = 1'b0;
    for (int i = 0; i < 4; i++)
      if (dv[i]) begin
        yy = 2'(i);
        v = 1'b1;
      end
    return pk(v, yy, v ? (4'b0001 << yy) : 4'b0000);
  endfunction
  function automatic logic [7:0] outs();
    return pk(valid, y, grant);
  endfunction
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  always @(negedge clk)
    if (inv_on) begin
      chk("inv_grant", {4'b0, grant}, {4'b0, valid ? (4'b0001 << y) : 4'b0000});
      if (!valid) chk("inv_idle_y", {6'b0, y}, 8'h00);
    end
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [7:0] prev;
    step();
    chk("preload", outs(), pk(1'b1, 2'd3, 4'b1000));
    inv_on = 1'b1;
    #2 rst_n = 1'b0;
    #1 chk("reset_async", outs(), pk(1'b0, 2'd0, 4'b0000));
    step();
    chk("reset_hold", outs(), pk(1'b0, 2'd0, 4'b0000));
    rst_n = 1'b1;
    step();
    chk("reset_release", outs(), pk(1'b1, 2'd3, 4'b1000));
    d = 4'b0000; step(); chk("d0000", outs(), pk(1'b0, 2'd0, 4'b0000));
    d = 4'b0001; step(); chk("d0001", outs(), pk(1'b1, 2'd0, 4'b0001));
    d = 4'b0010; step(); chk("d0010", outs(), pk(1'b1, 2'd1, 4'b0010));
    d = 4'b0100; step(); chk("d0100", outs(), pk(1'b1, 2'd2, 4'b0100));
    d = 4'b1000; step(); chk("d1000", outs(), pk(1'b1, 2'd3, 4'b1000));
    d = 4'b0110; step(); chk("d0110", outs(), pk(1'b1, 2'd2, 4'b0100));
    d = 4'b1011; step(); chk("d1011", outs(), pk(1'b1, 2'd3, 4'b1000));
    prev = model(4'b1011);
    for (int i = 0; i < 16; i++) begin
      d = 4'(i);
      #1 chk("sweep_pre", outs(), prev);
      step();
      chk("sweep", outs(), model(4'(i)));
      prev = model(4'(i));
    end
    d = 4'b0100; step(); chk("hold_load", outs(), pk(1'b1, 2'd2, 4'b0100));
    en = 1'b0;
    d = 4'b1000; step(); chk("hold_1000", outs(), pk(1'b1, 2'd2, 4'b0100));
    d = 4'b0001; step(); chk("hold_0001", outs(), pk(1'b1, 2'd2, 4'b0100));
    en = 1'b1;
    step(); chk("hold_release", outs(), pk(1'b1, 2'd0, 4'b0001));
    d = 4'b1000; step(); chk("mid_load", outs(), pk(1'b1, 2'd3, 4'b1000));
    #2 rst_n = 1'b0;
    #1 chk("mid_reset", outs(), pk(1'b0, 2'd0, 4'b0000));
    rst_n = 1'b1;
    d = 4'b0010;
    step(); chk("mid_resample", outs(), pk(1'b1, 2'd1, 4'b0010));
    inv_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
